// File: rtl/bpi_flash_reader_if.sv
// Burst request and read-data stream between user logic and the BPI flash reader.
// The slave modport is the reader side; the master modport is the user side.
interface bpi_flash_reader_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_len;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;

    modport slave (
        input  req_valid, req_addr, req_len, rd_ready,
        output req_ready, rd_valid, rd_data, rd_last, busy
    );

    modport master (
        output req_valid, req_addr, req_len, rd_ready,
        input  req_ready, rd_valid, rd_data, rd_last, busy
    );
endinterface

// File: rtl/bpi_flash_reader.sv
// Post-configuration reader for the x16 BPI NOR flash: timed CE#/OE# asynchronous
// reads with programmable wait/recovery clocks, returned as a valid/ready burst.
module bpi_flash_reader #(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int WAIT_CYC  = 6,
    parameter int RECOV_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done,
    bpi_flash_reader_if.slave  bus,
    output logic [ADDR_W-1:0]  flash_a,
    output logic               flash_a_oe,
    output logic               flash_ce_b,
    output logic               flash_oe_b,
    output logic               flash_we_b,
    input  logic [DATA_W-1:0]  flash_d
);
    typedef enum logic [2:0] {
        WAIT_DONE, IDLE, SETUP, ACCESS, HOLD, RECOV
    } state_t;

    localparam logic [5:0] WAIT_LOAD  = 6'(WAIT_CYC - 1);
    localparam logic [3:0] RECOV_LOAD = 4'(RECOV_CYC - 1);

    state_t            state_reg;
    logic [1:0]        done_sync_reg;
    logic              done_s;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        word_cnt_reg;
    logic [5:0]        wait_cnt_reg;
    logic [3:0]        recov_cnt_reg;
    logic              a_oe_reg;
    logic              ce_b_reg;
    logic              oe_b_reg;
    logic              req_ready_reg;
    logic              rd_valid_reg;
    logic              rd_last_reg;
    logic              busy_reg;
    logic [DATA_W-1:0] rd_data_reg;

    // done comes from the configuration logic with no clock relationship.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_sync_reg <= '0;
        end else begin
            done_sync_reg <= {done_sync_reg[0], done};
        end
    end
    assign done_s = done_sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WAIT_DONE;
            addr_reg      <= '0;
            word_cnt_reg  <= '0;
            wait_cnt_reg  <= '0;
            recov_cnt_reg <= '0;
            a_oe_reg      <= 1'b0;
            ce_b_reg      <= 1'b1;
            oe_b_reg      <= 1'b1;
            req_ready_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            rd_data_reg   <= '0;
        end else if (!done_s && state_reg != WAIT_DONE) begin
            // Losing DONE means the CPLD may drive the upper address lines again.
            state_reg     <= WAIT_DONE;
            a_oe_reg      <= 1'b0;
            ce_b_reg      <= 1'b1;
            oe_b_reg      <= 1'b1;
            req_ready_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                WAIT_DONE: begin
                    if (done_s) begin
                        state_reg     <= IDLE;
                        a_oe_reg      <= 1'b1;
                        req_ready_reg <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.req_valid) begin
                        state_reg     <= SETUP;
                        addr_reg      <= bus.req_addr;
                        word_cnt_reg  <= bus.req_len;
                        ce_b_reg      <= 1'b0;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                SETUP: begin
                    state_reg    <= ACCESS;
                    oe_b_reg     <= 1'b0;
                    wait_cnt_reg <= WAIT_LOAD;
                end
                ACCESS: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg    <= HOLD;
                        rd_data_reg  <= flash_d;
                        oe_b_reg     <= 1'b1;
                        rd_valid_reg <= 1'b1;
                        rd_last_reg  <= (word_cnt_reg == '0);
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 6'd1;
                    end
                end
                HOLD: begin
                    if (bus.rd_ready) begin
                        rd_valid_reg <= 1'b0;
                        rd_last_reg  <= 1'b0;
                        if (word_cnt_reg == '0) begin
                            state_reg     <= IDLE;
                            ce_b_reg      <= 1'b1;
                            req_ready_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                        end else begin
                            state_reg     <= RECOV;
                            word_cnt_reg  <= word_cnt_reg - 8'd1;
                            addr_reg      <= addr_reg + 1'b1;
                            recov_cnt_reg <= RECOV_LOAD;
                        end
                    end
                end
                RECOV: begin
                    if (recov_cnt_reg == '0) begin
                        state_reg    <= ACCESS;
                        oe_b_reg     <= 1'b0;
                        wait_cnt_reg <= WAIT_LOAD;
                    end else begin
                        recov_cnt_reg <= recov_cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= WAIT_DONE;
            endcase
        end
    end

    assign flash_a       = addr_reg;
    assign flash_a_oe    = a_oe_reg;
    assign flash_ce_b    = ce_b_reg;
    assign flash_oe_b    = oe_b_reg;
    assign flash_we_b    = 1'b1;
    assign bus.req_ready = req_ready_reg;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.rd_data   = rd_data_reg;
    assign bus.rd_last   = rd_last_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_bpi_flash_reader.sv
// Randomised self-checking bench for bpi_flash_reader against a word-level model
// of the flash contents and the burst timing formula.
module tb_bpi_flash_reader;
    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 16;
    localparam int WAIT_CYC  = 6;
    localparam int RECOV_CYC = 1;
    localparam int PERIOD    = 1 + RECOV_CYC + WAIT_CYC;

    logic              clk = 1'b0;
    logic              rst;
    logic              done;
    logic [ADDR_W-1:0] flash_a;
    logic              flash_a_oe;
    logic              flash_ce_b;
    logic              flash_oe_b;
    logic              flash_we_b;
    logic [DATA_W-1:0] flash_d;
    logic [15:0]       salt;
    int                n_checks = 0;
    int                n_fail   = 0;

    bpi_flash_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bpi_flash_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC), .RECOV_CYC(RECOV_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .bus        (bus.slave),
        .flash_a    (flash_a),
        .flash_a_oe (flash_a_oe),
        .flash_ce_b (flash_ce_b),
        .flash_oe_b (flash_oe_b),
        .flash_we_b (flash_we_b),
        .flash_d    (flash_d)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [ADDR_W-1:0] a);
        if (a == 25'h0000100) return 16'hA5C3;
        return a[15:0] ^ {a[24:16], 7'h35} ^ salt;
    endfunction

    // Flash drives the bus only while selected and output-enabled.
    always_comb begin
        flash_d = 16'hFFFF;
        if (!flash_ce_b && !flash_oe_b && flash_a_oe) flash_d = mem_val(flash_a);
    end

    // While OE# is low the address must equal what it was on the previous clock.
    logic [ADDR_W-1:0] prev_a = '0;
    always @(negedge clk) begin
        if (rst === 1'b0 && flash_oe_b === 1'b0) begin
            n_checks++;
            if (flash_a !== prev_a || flash_ce_b !== 1'b0) begin
                n_fail++;
                $display("FAIL addr_stable: a=%h prev=%h ce_b=%b required stable address with ce_b=0",
                         flash_a, prev_a, flash_ce_b);
            end
        end
        prev_a = flash_a;
    end

    // Issues one burst and scores every returned word against the model.
    task automatic do_burst(input logic [ADDR_W-1:0] addr, input int len,
                            input int stall_word, input int stall_clks);
        int k, i, stall_left, exp_k, budget, nwords;
        logic prev_v;
        logic [ADDR_W-1:0] a_i;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 30) begin @(negedge clk); k++; end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", bus.req_ready);
            return;
        end
        bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_len = 8'(len); bus.rd_ready = 1'b1;
        @(negedge clk); k = 1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (flash_ce_b !== 1'b0 || flash_oe_b !== 1'b1 || bus.busy !== 1'b1 || flash_a !== addr
            || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL setup: ce_b=%b oe_b=%b busy=%b a=%h ready=%b required 0 1 1 %h 0",
                     flash_ce_b, flash_oe_b, bus.busy, flash_a, bus.req_ready, addr);
        end
        i = 0; nwords = 0; prev_v = 1'b0; stall_left = stall_clks;
        budget = 2 + WAIT_CYC + (len + 1) * PERIOD + stall_clks + 10;
        while (i <= len && k < budget) begin
            if (bus.rd_valid === 1'b1) begin
                a_i = ADDR_W'((longint'(addr) + longint'(i)) % (longint'(1) << ADDR_W));
                if (!prev_v) begin
                    exp_k = 2 + WAIT_CYC + i * PERIOD + ((i > stall_word) ? stall_clks : 0);
                    n_checks++;
                    if (k != exp_k) begin
                        n_fail++;
                        $display("FAIL word_timing: word %0d valid at clock T+%0d required T+%0d", i, k, exp_k);
                    end
                    n_checks++;
                    if (bus.rd_data !== mem_val(a_i) || bus.rd_last !== 1'(i == len) || flash_a !== a_i) begin
                        n_fail++;
                        $display("FAIL word_data: word %0d data=%h last=%b a=%h required %h %b %h",
                                 i, bus.rd_data, bus.rd_last, flash_a, mem_val(a_i), i == len, a_i);
                    end
                end
                prev_v = 1'b1;
                if (i == stall_word && stall_left > 0) begin
                    n_checks++;
                    if (flash_oe_b !== 1'b1 || bus.rd_data !== mem_val(a_i)) begin
                        n_fail++;
                        $display("FAIL stall_hold: oe_b=%b data=%h required 1 %h",
                                 flash_oe_b, bus.rd_data, mem_val(a_i));
                    end
                    bus.rd_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.rd_ready = 1'b1;
                    i++; nwords++;
                    prev_v = 1'b0;
                end
            end else begin
                prev_v = 1'b0;
                bus.rd_ready = 1'b1;
                n_checks++;
                if (bus.rd_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stray_last: rd_last=%b with rd_valid=0 required 0", bus.rd_last);
                end
            end
            @(negedge clk); k++;
        end
        n_checks++;
        if (i <= len) begin
            n_fail++;
            $display("FAIL burst_timeout: got %0d words required %0d", nwords, len + 1);
        end
        n_checks++;
        if (flash_ce_b !== 1'b1 || bus.req_ready !== 1'b1 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: ce_b=%b ready=%b valid=%b busy=%b required 1 1 0 0",
                     flash_ce_b, bus.req_ready, bus.rd_valid, bus.busy);
        end
        $display("burst addr=%h len=%0d stall_word=%0d stall_clks=%0d words=%0d",
                 addr, len, stall_word, stall_clks, nwords);
    endtask

    task automatic test_reset();
        rst = 1'b1; done = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (flash_a !== '0 || flash_a_oe !== 1'b0 || flash_ce_b !== 1'b1 || flash_oe_b !== 1'b1
            || flash_we_b !== 1'b1 || bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0
            || bus.rd_last !== 1'b0 || bus.rd_data !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: a=%h a_oe=%b ce=%b oe=%b we=%b rdy=%b v=%b l=%b d=%h busy=%b required all idle",
                     flash_a, flash_a_oe, flash_ce_b, flash_oe_b, flash_we_b, bus.req_ready,
                     bus.rd_valid, bus.rd_last, bus.rd_data, bus.busy);
        end
        done = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (flash_a_oe !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_early: a_oe=%b ready=%b after 2 clocks required 0 0", flash_a_oe, bus.req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (flash_a_oe !== 1'b1 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_rise: a_oe=%b ready=%b after 3 clocks required 1 1", flash_a_oe, bus.req_ready);
        end
        $display("reset and done rise done");
    endtask

    task automatic test_single();
        do_burst(25'h0000100, 0, -1, 0);
    endtask

    task automatic test_burst_stall();
        do_burst(25'h0000010, 3, 1, 5);
    endtask

    task automatic test_wrap();
        do_burst(25'h1FFFFFE, 2, -1, 0);
    endtask

    task automatic test_random();
        int len;
        for (int n = 0; n < 6; n++) begin
            len = int'($urandom_range(0, 5));
            do_burst(ADDR_W'($urandom), len, int'($urandom_range(0, len)), int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_done_fall();
        int k, seen;
        k = 0; seen = 0;
        while (bus.req_ready !== 1'b1 && k < 30) begin @(negedge clk); k++; end
        bus.req_valid = 1'b1; bus.req_addr = ADDR_W'($urandom); bus.req_len = 8'd7; bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (!(seen == 1 && flash_oe_b === 1'b0) && k < 100) begin
            if (bus.rd_valid === 1'b1) seen++;
            @(negedge clk); k++;
        end
        n_checks++;
        if (seen != 1 || flash_oe_b !== 1'b0) begin
            n_fail++;
            $display("FAIL done_fall_setup: words=%0d oe_b=%b required 1 0", seen, flash_oe_b);
        end
        done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_last !== 1'b0) begin
                n_fail++;
                $display("FAIL done_fall_last: rd_last=%b required 0", bus.rd_last);
            end
        end
        n_checks++;
        if (bus.rd_valid !== 1'b0 || flash_a_oe !== 1'b0 || flash_ce_b !== 1'b1 || flash_oe_b !== 1'b1
            || bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_fall_release: v=%b a_oe=%b ce=%b oe=%b busy=%b rdy=%b required 0 0 1 1 0 0",
                     bus.rd_valid, flash_a_oe, flash_ce_b, flash_oe_b, bus.busy, bus.req_ready);
        end
        done = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || flash_a_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL done_recover: ready=%b a_oe=%b required 1 1", bus.req_ready, flash_a_oe);
        end
        $display("done fall during word 2 access done");
    endtask

    task automatic test_reset_in_hold();
        int k;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 30) begin @(negedge clk); k++; end
        bus.req_valid = 1'b1; bus.req_addr = ADDR_W'($urandom); bus.req_len = 8'd3; bus.rd_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (bus.rd_valid !== 1'b1 && k < 30) begin @(negedge clk); k++; end
        n_checks++;
        if (bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reach: rd_valid=%b required 1", bus.rd_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (flash_a !== '0 || flash_a_oe !== 1'b0 || flash_ce_b !== 1'b1 || flash_oe_b !== 1'b1
            || bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0
            || bus.rd_data !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_hold: a=%h a_oe=%b ce=%b oe=%b rdy=%b v=%b l=%b d=%h busy=%b required reset values",
                     flash_a, flash_a_oe, flash_ce_b, flash_oe_b, bus.req_ready, bus.rd_valid,
                     bus.rd_last, bus.rd_data, bus.busy);
        end
        bus.rd_ready = 1'b1;
        $display("reset in hold done");
    endtask

    task automatic test_max_burst();
        do_burst(ADDR_W'($urandom), 255, -1, 0);
    endtask

    initial begin
        salt = 16'($urandom);
        test_reset();
        test_single();
        test_burst_stall();
        test_wrap();
        test_random();
        test_done_fall();
        test_reset_in_hold();
        test_max_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
